// File: rtl/bounce_gen.sv
`default_nettype none
// ============================================================================
// Module   : bounce_gen
// Purpose  : Turns a clean level into a bouncing contact waveform with
//            LFSR-randomised glitch spacing, a settle hold and a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module bounce_gen #(
    parameter int          BOUNCES    = 3,
    parameter int          GAP_W      = 4,
    parameter int          SETTLE_CYC = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic enable,
    output logic bounce_out,
    output logic busy,
    output logic done
);

    localparam logic [1:0]       c_IDLE      = 2'd0;
    localparam logic [1:0]       c_BOUNCE    = 2'd1;
    localparam logic [1:0]       c_SETTLE    = 2'd2;
    localparam logic [15:0]      c_TAPS      = 16'hB400;
    localparam logic [4:0]       c_LAST_EDGE = 5'(2 * BOUNCES);
    localparam logic [7:0]       c_SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [GAP_W-1:0] c_GAP_ONE   = {{(GAP_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [15:0]      r_lfsr;
    logic [4:0]       r_edge_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [7:0]       r_settle_cnt;
    logic             r_bounce_out;
    logic             r_busy;
    logic             r_done;

    logic [15:0]      w_lfsr_shift;
    logic [15:0]      w_lfsr_next;
    logic [GAP_W-1:0] w_gap_raw;
    logic [GAP_W-1:0] w_gap;

    logic [1:0]       w_state_nx;
    logic [4:0]       w_edge_nx;
    logic [GAP_W-1:0] w_gap_nx;
    logic [7:0]       w_settle_nx;
    logic             w_out_nx;
    logic             w_busy_nx;
    logic             w_done_nx;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    assign w_lfsr_shift = {1'b0, r_lfsr[15:1]};
    assign w_lfsr_next  = r_lfsr[0] ? (w_lfsr_shift ^ c_TAPS) : w_lfsr_shift;

    // A zero gap would stall the burst, so it is promoted to one cycle
    assign w_gap_raw = r_lfsr[GAP_W-1:0];
    assign w_gap     = (w_gap_raw == '0) ? c_GAP_ONE : w_gap_raw;

    always_comb begin
        w_state_nx  = r_state;
        w_edge_nx   = r_edge_cnt;
        w_gap_nx    = r_gap_cnt;
        w_settle_nx = r_settle_cnt;
        w_out_nx    = r_bounce_out;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;

        if ((r_state != c_IDLE) && !enable) begin
            w_state_nx  = c_IDLE;
            w_out_nx    = in;
            w_busy_nx   = 1'b0;
            w_edge_nx   = '0;
            w_gap_nx    = '0;
            w_settle_nx = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!enable) begin
                        w_out_nx = in;
                    end else if (in != r_bounce_out) begin
                        w_state_nx = c_BOUNCE;
                        w_out_nx   = ~r_bounce_out;
                        w_busy_nx  = 1'b1;
                        w_edge_nx  = 5'd1;
                        w_gap_nx   = w_gap;
                    end
                end
                c_BOUNCE: begin
                    if (r_gap_cnt == c_GAP_ONE) begin
                        if (r_edge_cnt < c_LAST_EDGE) begin
                            w_out_nx  = ~r_bounce_out;
                            w_edge_nx = r_edge_cnt + 5'd1;
                            w_gap_nx  = w_gap;
                        end else begin
                            // Final step lands on the latest level of in
                            w_out_nx    = in;
                            w_state_nx  = c_SETTLE;
                            w_settle_nx = c_SETTLE_LD;
                            w_gap_nx    = '0;
                        end
                    end else begin
                        w_gap_nx = r_gap_cnt - c_GAP_ONE;
                    end
                end
                c_SETTLE: begin
                    if (r_settle_cnt == 8'd1) begin
                        w_state_nx  = c_IDLE;
                        w_busy_nx   = 1'b0;
                        w_done_nx   = 1'b1;
                        w_settle_nx = '0;
                        w_edge_nx   = '0;
                    end else begin
                        w_settle_nx = r_settle_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nx = c_IDLE;
                    w_busy_nx  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_lfsr       <= SEED;
            r_edge_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_settle_cnt <= '0;
            r_bounce_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_lfsr       <= w_lfsr_next;
            r_edge_cnt   <= w_edge_nx;
            r_gap_cnt    <= w_gap_nx;
            r_settle_cnt <= w_settle_nx;
            r_bounce_out <= w_out_nx;
            r_busy       <= w_busy_nx;
            r_done       <= w_done_nx;
        end
    end

    assign bounce_out = r_bounce_out;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_gen
// Purpose  : Self-checking bench for bounce_gen against an event-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_gen;

    localparam int          BOUNCES    = 3;
    localparam int          GAP_W      = 4;
    localparam int          SETTLE_CYC = 8;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic in     = 1'b0;
    logic enable = 1'b0;
    logic bounce_out;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    bounce_gen #(
        .BOUNCES   (BOUNCES),
        .GAP_W     (GAP_W),
        .SETTLE_CYC(SETTLE_CYC),
        .SEED      (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .enable    (enable),
        .bounce_out(bounce_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: absolute cycle index plus the cycle of the next scheduled event
    int          m_mode;   // 0 idle, 1 bouncing, 2 settling
    int          m_n;
    int          m_next;
    int          m_edges;
    logic        m_out;
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_lfsr;

    function automatic int gap_of(input logic [15:0] l);
        int g;
        g = int'(l) % (1 << GAP_W);
        return (g == 0) ? 1 : g;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_n     = 0;
        m_next  = 0;
        m_edges = 0;
        m_out   = 1'b0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_lfsr  = SEED;
    endtask

    task automatic model_tick(input logic i, input logic e);
        m_done = 1'b0;
        if (m_mode != 0 && !e) begin
            m_mode = 0;
            m_out  = i;
        end else begin
            case (m_mode)
                0: begin
                    if (!e) m_out = i;
                    else if (i != m_out) begin
                        m_out   = ~m_out;
                        m_edges = 1;
                        m_next  = m_n + gap_of(m_lfsr);
                        m_mode  = 1;
                    end
                end
                1: begin
                    if (m_n == m_next) begin
                        if (m_edges < 2 * BOUNCES) begin
                            m_out   = ~m_out;
                            m_edges = m_edges + 1;
                            m_next  = m_n + gap_of(m_lfsr);
                        end else begin
                            m_out  = i;
                            m_mode = 2;
                            m_next = m_n + SETTLE_CYC;
                        end
                    end
                end
                default: begin
                    if (m_n == m_next) begin
                        m_mode = 0;
                        m_done = 1'b1;
                    end
                end
            endcase
        end
        m_busy = (m_mode != 0);
        m_lfsr = lfsr_adv(m_lfsr);
        m_n    = m_n + 1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic i, input logic e);
        in     = i;
        enable = e;
        @(posedge clk);
        model_tick(i, e);
        #1;
    endtask

    task automatic step(input logic i, input logic e);
        tick(i, e);
        check("out_vs_model", bounce_out, m_out);
        check("busy_vs_model", busy, m_busy);
        check("done_vs_model", done, m_done);
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        in     = 1'b0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", bounce_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        model_reset();
        reset = 1'b1;
    endtask

    typedef struct {
        logic i;
        logic e;
        logic out;
        logic bsy;
        logic dn;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int   edges;
        int   dones;
        int   last_edge_k;
        int   done_k;
        int   e1;
        int   e2;
        int   ph;
        logic prev;
        logic ci;
        bit   after_done;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Bypass, first edge of a burst, and abort, from fixed vectors
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick(tbl[k].i, tbl[k].e);
            check("tbl_out", bounce_out, tbl[k].out);
            check("tbl_busy", busy, tbl[k].bsy);
            check("tbl_done", done, tbl[k].dn);
        end

        // Held 0->1: seven edges, settle hold, one done pulse
        do_reset();
        step(1'b0, 1'b1);
        edges = 0; dones = 0; prev = bounce_out; last_edge_k = 0; done_k = 0;
        for (int k = 0; k < 400 && dones == 0; k++) begin
            step(1'b1, 1'b1);
            if (bounce_out !== prev) begin edges++; last_edge_k = k; end
            if (done) begin dones++; done_k = k; end
            prev = bounce_out;
        end
        check_int("held_edges", edges, 2 * BOUNCES + 1);
        check_int("held_dones", dones, 1);
        check_int("held_settle_len", done_k - last_edge_k, SETTLE_CYC);
        check("held_final", bounce_out, 1'b1);
        check("held_busy_low", busy, 1'b0);
        step(1'b1, 1'b1);
        check("held_done_single", done, 1'b0);

        // in returns to 0 after edge #3: six edges, ends low
        do_reset();
        step(1'b0, 1'b1);
        edges = 0; dones = 0; prev = bounce_out;
        for (int k = 0; k < 400 && dones == 0; k++) begin
            step((edges >= 3) ? 1'b0 : 1'b1, 1'b1);
            if (bounce_out !== prev) edges++;
            if (done) dones++;
            prev = bounce_out;
        end
        check_int("ret_edges", edges, 2 * BOUNCES);
        check_int("ret_dones", dones, 1);
        check("ret_final", bounce_out, 1'b0);

        // enable dropped after edge #2
        do_reset();
        step(1'b0, 1'b1);
        edges = 0; prev = bounce_out;
        for (int k = 0; k < 100 && edges < 2; k++) begin
            step(1'b1, 1'b1);
            if (bounce_out !== prev) edges++;
            prev = bounce_out;
        end
        check_int("abort_reached_edge2", edges, 2);
        step(1'b1, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_out", bounce_out, 1'b1);
        check("abort_done", done, 1'b0);
        edges = 0; dones = 0; prev = bounce_out;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            if (bounce_out !== prev) edges++;
            if (done) dones++;
            prev = bounce_out;
        end
        check_int("abort_no_edges", edges, 0);
        check_int("abort_no_done", dones, 0);

        // in toggles during settle: ignored until done, then a fresh burst
        do_reset();
        step(1'b0, 1'b1);
        e1 = 0; e2 = 0; ph = 0; ci = 1'b1; prev = bounce_out; after_done = 1'b0;
        for (int k = 0; k < 800 && ph < 2; k++) begin
            if (m_mode == 2) ci = 1'b0;
            step(ci, 1'b1);
            if (after_done) begin
                check("settle_restart_busy", busy, 1'b1);
                after_done = 1'b0;
            end
            if (bounce_out !== prev) begin
                if (ph == 0) e1++;
                else e2++;
            end
            prev = bounce_out;
            if (done) begin
                ph++;
                after_done = (ph == 1);
            end
        end
        check_int("settle_first_edges", e1, 2 * BOUNCES + 1);
        check_int("settle_second_edges", e2, 2 * BOUNCES + 1);
        check_int("settle_dones", ph, 2);

        // Asynchronous reset mid-burst, then a burst from the reseeded LFSR
        do_reset();
        step(1'b0, 1'b1);
        edges = 0; prev = bounce_out;
        for (int k = 0; k < 100 && edges < 2; k++) begin
            step(1'b1, 1'b1);
            if (bounce_out !== prev) edges++;
            prev = bounce_out;
        end
        check("async_pre_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_out", bounce_out, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_done", done, 1'b0);
        @(posedge clk);
        #1;
        check("async_hold_out", bounce_out, 1'b0);
        model_reset();
        reset = 1'b1;
        edges = 0; dones = 0; prev = bounce_out;
        for (int k = 0; k < 400 && dones == 0; k++) begin
            step(1'b1, 1'b1);
            if (bounce_out !== prev) edges++;
            if (done) dones++;
            prev = bounce_out;
        end
        check_int("async_after_edges", edges, 2 * BOUNCES + 1);
        check_int("async_after_dones", dones, 1);

        // Randomised traffic against the model
        do_reset();
        ci = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            logic en_r;
            en_r = enable;
            if ($urandom_range(0, 11) == 0) ci = ~ci;
            if (en_r) begin
                if ($urandom_range(0, 49) == 0) en_r = 1'b0;
            end else begin
                if ($urandom_range(0, 2) == 0) en_r = 1'b1;
            end
            step(ci, en_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter BOUNCES, default 3: glitch pairs per transition; legal range 1..15.
REQ-002 Parameter GAP_W, default 4: width of the random inter-edge gap field; legal range 2..8.
REQ-003 Parameter SETTLE_CYC, default 8: stable hold cycles after the final edge; legal range 1..255.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in  input  1  clean level to emulate; synchronous to clk.
REQ-008 enable  input  1  1 = bounce emulation, 0 = bypass.
REQ-009 bounce_out  output  1  emulated bouncing switch/contact signal.
REQ-010 busy  output  1  high in BOUNCE and SETTLE.
REQ-011 done  output  1  one-cycle pulse when SETTLE completes.

Function
REQ-012 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle out of reset.
REQ-013 Gap value g = LFSR[GAP_W-1:0] at load time; g=0 is replaced by 1; range 1..2^GAP_W-1.
REQ-014 FSM states: IDLE, BOUNCE, SETTLE; all outputs registered.
REQ-015 IDLE, enable=0: bounce_out <= in each cycle (1-cycle latency); busy=0; no done.
REQ-016 IDLE, enable=1, in != bounce_out at edge t: at t+1 state=BOUNCE, bounce_out toggles (edge #1), edge count=1, gap loaded.
REQ-017 BOUNCE: each subsequent edge occurs exactly g cycles after the previous edge; a new g is loaded at every edge.
REQ-018 BOUNCE: edges #2..#2*BOUNCES are plain toggles of bounce_out.
REQ-019 BOUNCE: on the gap expiry after edge #2*BOUNCES, bounce_out <= current in (no edge if already equal); state=SETTLE; settle counter loaded.
REQ-020 in changing during BOUNCE does not alter the edge count; only the final step of REQ-019 reflects the latest in.
REQ-021 SETTLE: bounce_out held for SETTLE_CYC cycles; changes on in ignored.
REQ-022 SETTLE end: done=1 for exactly one cycle; state=IDLE in the same cycle; busy=0 from that cycle.
REQ-023 A pending in/bounce_out mismatch at SETTLE end starts a new burst per REQ-016 on the next cycle.
REQ-024 enable=0 during BOUNCE or SETTLE: abort; next cycle state=IDLE, bounce_out=in, busy=0, no done pulse.
REQ-025 Total edges per uninterrupted burst: 2*BOUNCES+1 if in is stable, 2*BOUNCES if in returned to its original level.
REQ-026 Counters: edge count 5 bits, gap counter GAP_W bits, settle counter 8 bits; no wrap permitted within legal ranges.

Reset
REQ-027 reset=0 forces immediately, independent of clk: state=IDLE, bounce_out=0, busy=0, done=0, LFSR=SEED, all counters 0.
REQ-028 Reset asserted mid-burst discards the burst; no done pulse is generated.
REQ-029 After reset release, the first cycle evaluates REQ-015/REQ-016 normally.

Verification
REQ-030 enable=0, in 0->1: bounce_out=1 one cycle later; busy and done stay 0.
REQ-031 Defaults, enable=1, in 0->1 held: exactly 7 edges, final level 1, gaps match the bench LFSR model (1..15); then 8 stable cycles; one done pulse; busy falls.
REQ-032 Defaults, in 0->1 then back to 0 after edge #3: 6 edges total, final level 0, done pulse after 8 settle cycles.
REQ-033 enable dropped after edge #2: next cycle busy=0, bounce_out=in, no done, no further edges.
REQ-034 in toggles during SETTLE: no edge until done; new 7-edge burst starts on the cycle after done.
REQ-035 reset=0 asynchronously mid-BOUNCE: bounce_out, busy, and done go 0 before the next clk edge; LFSR restarts at SEED.
